// File: rtl/hero_motion.sv
// Grid-locked hero movement controller: WASD key on a frame tick -> wall query to the
// tile map -> glide one tile in STEP-pixel increments, one increment per frame tick.
module hero_motion #(
    parameter int TILE    = 16,
    parameter int STEP    = 2,
    parameter int START_X = 16,
    parameter int START_Y = 16,
    parameter int X_MAX   = 240,
    parameter int Y_MAX   = 224
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       HERO_RESET,
    input  logic       FRAME_TICK,
    input  logic [7:0] KEYCODE,
    output logic       MAP_REQ,
    output logic [3:0] MAP_TX,
    output logic [3:0] MAP_TY,
    input  logic       MAP_ACK,
    input  logic       MAP_WALL,
    output logic [7:0] HERO_X,
    output logic [7:0] HERO_Y,
    output logic [2:0] HERO_DIR,
    output logic       MOVING
);

    localparam int         TILE_SH  = $clog2(TILE);
    localparam logic [7:0] TILE8    = 8'(TILE);
    localparam logic [7:0] STEP8    = 8'(STEP);
    localparam logic [7:0] LAST_CNT = 8'(TILE / STEP - 1);
    // Largest coordinate from which a +TILE move still lands inside the field
    localparam logic [7:0] X_LIM    = 8'(X_MAX - TILE);
    localparam logic [7:0] Y_LIM    = 8'(Y_MAX - TILE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] QUERY = 2'd1;
    localparam logic [1:0] MOVE  = 2'd2;

    logic [1:0] state;
    logic       mv_y;
    logic       mv_neg;
    logic [7:0] step_cnt;

    logic       key_ok;
    logic [2:0] key_dir;
    logic       key_y;
    logic       key_neg;
    logic       in_bounds;
    logic [7:0] tgt_x;
    logic [7:0] tgt_y;

    function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic neg);
        return neg ? (pos - STEP8) : (pos + STEP8);
    endfunction

    // Key decode; the target is only used when the bounds test has already passed
    always_comb begin
        key_ok    = 1'b0;
        key_dir   = 3'd0;
        key_y     = 1'b0;
        key_neg   = 1'b0;
        in_bounds = 1'b0;
        tgt_x     = HERO_X;
        tgt_y     = HERO_Y;
        case (KEYCODE)
            8'h16: begin
                key_ok = 1'b1; key_dir = 3'd1; key_y = 1'b1;
                in_bounds = (HERO_Y <= Y_LIM);
                tgt_y = HERO_Y + TILE8;
            end
            8'h1A: begin
                key_ok = 1'b1; key_dir = 3'd2; key_y = 1'b1; key_neg = 1'b1;
                in_bounds = (HERO_Y >= TILE8);
                tgt_y = HERO_Y - TILE8;
            end
            8'h04: begin
                key_ok = 1'b1; key_dir = 3'd3; key_neg = 1'b1;
                in_bounds = (HERO_X >= TILE8);
                tgt_x = HERO_X - TILE8;
            end
            8'h07: begin
                key_ok = 1'b1; key_dir = 3'd4;
                in_bounds = (HERO_X <= X_LIM);
                tgt_x = HERO_X + TILE8;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET || HERO_RESET) begin
            state    <= IDLE;
            HERO_X   <= 8'(START_X);
            HERO_Y   <= 8'(START_Y);
            HERO_DIR <= 3'd1;
            MOVING   <= 1'b0;
            MAP_REQ  <= 1'b0;
            MAP_TX   <= 4'd0;
            MAP_TY   <= 4'd0;
            mv_y     <= 1'b0;
            mv_neg   <= 1'b0;
            step_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (FRAME_TICK && key_ok) begin
                        HERO_DIR <= key_dir;
                        if (in_bounds) begin
                            MAP_REQ <= 1'b1;
                            MAP_TX  <= 4'(tgt_x >> TILE_SH);
                            MAP_TY  <= 4'(tgt_y >> TILE_SH);
                            mv_y    <= key_y;
                            mv_neg  <= key_neg;
                            state   <= QUERY;
                        end
                    end
                end
                QUERY: begin
                    if (MAP_ACK) begin
                        MAP_REQ <= 1'b0;
                        if (MAP_WALL) begin
                            state <= IDLE;
                        end else begin
                            state    <= MOVE;
                            MOVING   <= 1'b1;
                            step_cnt <= 8'd0;
                        end
                    end
                end
                MOVE: begin
                    if (FRAME_TICK) begin
                        if (mv_y) HERO_Y <= step_pos(HERO_Y, mv_neg);
                        else      HERO_X <= step_pos(HERO_X, mv_neg);
                        step_cnt <= step_cnt + 8'd1;
                        if (step_cnt == LAST_CNT) begin
                            state  <= IDLE;
                            MOVING <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
